// File: rtl/toggle_cover_pkg.sv
// Shared types and constants for the toggle-coverage report scheduler.
package toggle_cover_pkg;

  localparam int unsigned COVER_IDX_W         = 64;
  localparam int unsigned COVER_TOTAL_DEFAULT = 38253;

  typedef logic [COVER_IDX_W-1:0] cover_idx_t;

endpackage

// File: rtl/toggle_cover_rr_pick.sv
// Combinational round-robin picker: first set mask bit at or above ptr_i, wrapping to bit 0.
module toggle_cover_rr_pick #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] mask_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic             found_o,
  output logic [PTR_W-1:0] idx_o
);

  // One extra bit so ptr + offset cannot overflow before the wrap subtraction.
  localparam int unsigned JW = PTR_W + 1;

  logic [JW-1:0] j;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      j = {1'b0, ptr_i} + JW'(i);
      if (j >= JW'(WIDTH)) begin
        j = j - JW'(WIDTH);
      end
      if (!found_o && mask_i[j]) begin
        found_o = 1'b1;
        idx_o   = j[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/toggle_cover_sched.sv
// Captures toggle hits into a pending mask and drains them round-robin as absolute cover indices.
// Optional COVER_DEDUP_EN adds a sticky seen mask so each bit is reported at most once per reset.
module toggle_cover_sched
  import toggle_cover_pkg::*;
#(
  parameter int unsigned WIDTH       = 27,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned COVER_TOTAL = COVER_TOTAL_DEFAULT,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] valid,
  output logic             out_valid,
  input  logic             out_ready,
  output cover_idx_t       out_index,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_check
    $error("toggle_cover_sched: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
  end

  logic [WIDTH-1:0] pending_q, pending_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  cover_idx_t       out_index_q, out_index_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [WIDTH-1:0] hit, load_mask, drop_hits;
  logic             slot_free, load, pick_found;
  logic [PTR_W-1:0] pick_idx;

`ifdef COVER_DEDUP_EN
  logic [WIDTH-1:0] seen_q, seen_d;
`endif

  toggle_cover_rr_pick #(
    .WIDTH (WIDTH),
    .PTR_W (PTR_W)
  ) u_pick (
    .mask_i  (pending_q),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
`ifdef COVER_DEDUP_EN
    hit    = valid & ~seen_q;
    seen_d = seen_q | hit;
`else
    hit    = valid;
`endif
    slot_free   = !out_valid_q || out_ready;
    load        = slot_free && pick_found;
    load_mask   = load ? (WIDTH'(1) << pick_idx) : '0;
    pending_d   = (pending_q & ~load_mask) | hit;
    // A bit being loaded this cycle re-enters pending, so it is not a coalesced drop.
    drop_hits   = hit & pending_q & ~load_mask;
    out_valid_d = slot_free ? pick_found : out_valid_q;
    out_index_d = load ? (cover_idx_t'(COVER_INDEX) + cover_idx_t'(pick_idx)) : out_index_q;
    ptr_d       = ptr_q;
    if (load) begin
      ptr_d = (pick_idx == PTR_W'(WIDTH - 1)) ? '0 : pick_idx + PTR_W'(1);
    end
    drop_d = drop_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (drop_hits[i] && (drop_d != '1)) begin
        drop_d = drop_d + CNT_W'(1);
      end
    end
    busy_d = (|pending_d) || out_valid_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      busy_q      <= 1'b0;
      drop_q      <= '0;
`ifdef COVER_DEDUP_EN
      seen_q      <= '0;
`endif
    end else begin
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
`ifdef COVER_DEDUP_EN
      seen_q      <= seen_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign busy      = busy_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_toggle_cover_sched.sv
// Directed bench for toggle_cover_sched with WIDTH=27 and COVER_INDEX=100.
module tb_toggle_cover_sched;

  localparam int unsigned W    = 27;
  localparam int unsigned BASE = 100;

`ifdef COVER_DEDUP_EN
  localparam int unsigned EXP_DROP  = 0;
  localparam int unsigned EXP_REP7  = 1;
`else
  localparam int unsigned EXP_DROP  = 1;
  localparam int unsigned EXP_REP7  = 2;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [W-1:0]  valid;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_index;
  logic          busy;
  logic [15:0]   drop_cnt;

  int n_asserts = 0;
  int n_fail    = 0;
  int n_rep;

  toggle_cover_sched #(
    .WIDTH       (W),
    .COVER_INDEX (BASE),
    .COVER_TOTAL (38253),
    .CNT_W       (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .valid     (valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid = '0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    valid     = '0;
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_index", out_index, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);

    // Single hit on bit 5: report two edges later, for exactly one cycle.
    valid = W'(1) << 5;
    step();
    valid = '0;
    chk("t1_valid_lat1", 64'(out_valid), 64'd0);
    chk("t1_busy_lat1", 64'(busy), 64'd1);
    step();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_index", out_index, 64'd105);
    step();
    chk("t1_valid_done", 64'(out_valid), 64'd0);
    chk("t1_busy_done", 64'(busy), 64'd0);
    chk("t1_index_hold", out_index, 64'd105);

    // Full burst from a fresh pointer drains in ascending order, one per cycle.
    do_reset();
    valid = '1;
    step();
    valid = '0;
    chk("t2_valid_lat1", 64'(out_valid), 64'd0);
    for (int i = 0; i < 27; i++) begin
      step();
      chk("t2_valid", 64'(out_valid), 64'd1);
      chk("t2_index", out_index, 64'(BASE + i));
    end
    step();
    chk("t2_valid_end", 64'(out_valid), 64'd0);
    chk("t2_busy_end", 64'(busy), 64'd0);

    // Backpressure: output holds bit 1, bit 3 pending and hit again -> coalesced.
    do_reset();
    out_ready = 1'b0;
    valid = (W'(1) << 1) | (W'(1) << 3);
    step();
    valid = '0;
    step();
    chk("t3_valid", 64'(out_valid), 64'd1);
    chk("t3_index", out_index, 64'd101);
    step();
    step();
    valid = W'(1) << 3;
    step();
    valid = '0;
    chk("t3_drop", 64'(drop_cnt), 64'(EXP_DROP));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_index", out_index, 64'd101);
    end
    out_ready = 1'b1;
    step();
    chk("t3_second_valid", 64'(out_valid), 64'd1);
    chk("t3_second_index", out_index, 64'd103);
    step();
    chk("t3_end_valid", 64'(out_valid), 64'd0);
    chk("t3_end_busy", 64'(busy), 64'd0);
    chk("t3_end_drop", 64'(drop_cnt), 64'(EXP_DROP));

    // Bit 7 hit twice, far apart.
    do_reset();
    n_rep = 0;
    for (int i = 0; i < 30; i++) begin
      valid = (i == 0 || i == 20) ? (W'(1) << 7) : '0;
      step();
      if (out_valid) begin
        n_rep++;
        chk("t4_index", out_index, 64'd107);
      end
    end
    valid = '0;
    chk("t4_reports", 64'(n_rep), 64'(EXP_REP7));

    // Round-robin wrap: after granting 20, pending {2,25} yields 25 then 2.
    do_reset();
    valid = W'(1) << 20;
    step();
    valid = '0;
    step();
    chk("t5_first_index", out_index, 64'd120);
    step();
    chk("t5_idle", 64'(out_valid), 64'd0);
    valid = (W'(1) << 2) | (W'(1) << 25);
    step();
    valid = '0;
    step();
    chk("t5_idx_a", out_index, 64'd125);
    step();
    chk("t5_idx_b", out_index, 64'd102);
    step();
    chk("t5_end_valid", 64'(out_valid), 64'd0);

    // Reset mid-drain, with valid held high during reset.
    do_reset();
    valid = '1;
    step();
    valid = '0;
    step();
    step();
    step();
    step();
    chk("t6_mid_index", out_index, 64'd103);
    reset = 1'b1;
    valid = '1;
    step();
    reset = 1'b0;
    valid = '0;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_drop", 64'(drop_cnt), 64'd0);
    chk("t6_index", out_index, 64'd0);
    n_rep = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_valid) n_rep++;
    end
    chk("t6_no_reports", 64'(n_rep), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
